dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter sharing the single 64-bit data memory between the CPU load/store path (port 0) and a debug/DMA requester (port 1). Each requester uses a valid/ready request handshake with a registered response one cycle after acceptance. The arbiter drives the memory's address, write-data and write-enable pins: at most one access per cycle, round-robin fairness, and an optional bounded lock for multi-beat sequences such as read-modify-write.

## Interface
- WIDTH, 64: data and address width.
- MAX_LOCK, 15: maximum consecutive locked grants to one port before a forced release; counter width is clog2(MAX_LOCK+1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- reqN_valid  in  1  request from port N (N = 0, 1).
- reqN_addr  in  WIDTH  byte address, forwarded unmodified; alignment is the requester's responsibility.
- reqN_wdata  in  WIDTH  store data.
- reqN_word_we, reqN_byte_we  in  1 each  write type; both 0 means read.
- reqN_lock  in  1  request a lock; the port keeps the grant after this beat.
- reqN_ready  out  1  combinational grant; the beat is accepted when valid && ready.
- rspN_valid  out  1  one-cycle response pulse.
- rspN_rdata  out  WIDTH  memory data captured at acceptance; pre-write contents for stores.
- mem_addr, mem_wdata  out  WIDTH  to data memory.
- mem_word_we, mem_byte_we  out  1  to data memory.
- mem_rdata  in  WIDTH  combinational read data from memory.
- owner  out  1  port granted this cycle; valid only when some ready is 1.
- err  out  1  sticky illegal-request flag.

## Operation
- State register: IDLE, GNT0, GNT1, LCK0, LCK1. It records the last cycle's winner and whether that winner holds a lock. Reset state: IDLE with the round-robin pointer favouring port 0.
- Arbitration each cycle:
  - In LCKn, if reqn_valid is 1, port n wins unconditionally.
  - Otherwise, a single valid port wins.
  - If both ports are valid, the port that did not win last wins. From IDLE after reset, port 0 wins.
- Lock:
  - A beat accepted with reqn_lock=1 moves the FSM to LCKn and increments lock_cnt.
  - A beat with lock=0 moves it to GNTn and clears lock_cnt.
  - In LCKn, if reqn_valid=0 for a cycle, the lock drops (next state IDLE, or the other port's GNT if that port wins) and lock_cnt clears.
  - When a locked grant makes lock_cnt reach MAX_LOCK, the next state is GNTn regardless of lock. The other port then wins the next contested cycle.
- No winner: mem_word_we=mem_byte_we=0, mem_addr=0, mem_wdata=0, both ready=0, next state IDLE. IDLE does not change the round-robin pointer.
- Winner: mem_* = that port's request fields, combinationally.
- Illegal request (word_we && byte_we, both 1): the request is accepted, mem_word_we=1, mem_byte_we=0, and err is set to 1 until reset.
- Response: on acceptance, rspn_rdata is loaded from mem_rdata and rspn_valid=1 for the next cycle only. rdata holds its value until the next response on that port.

## Timing
- Reset asserted (reset=0, asynchronous): state IDLE, lock_cnt=0, rsp0/1_valid=0, rsp0/1_rdata=0, err=0. While reset=0, ready0/1=0 and mem_word_we=mem_byte_we=0 regardless of inputs.
- Request-to-ready: 0 cycles, combinational. Acceptance-to-response: 1 cycle.
- Throughput: one beat per cycle total; back-to-back beats from the same port are allowed.
- Write lands at the accept edge; a read of the same address in the next beat sees the new data.
- Reset asserted mid-lock: the lock is dropped, and a pending response pulse is cancelled (rsp_valid=0).
- reqN_* signals may change freely while ready=0; there is no hold requirement before acceptance.

## Test plan
- Post-reset contention: both ports read at cycle 1 (addr 0x10 and 0x18, memory 0xA and 0xB). Expected: ready0=1, ready1=0; next cycle ready1=1. rsp0_rdata=0xA at cycle 2, rsp1_rdata=0xB at cycle 3.
- Round-robin: both ports valid for 6 cycles with no lock. Expected: owner sequence 0,1,0,1,0,1, with exactly one rsp pulse per accepted beat.
- Locked read-modify-write: port 1 reads 0x20 (lock=1), then writes 0x55 (lock=0) while port 0 is valid throughout. Expected: port 1 wins both beats, port 0 wins cycle 3, rsp1_rdata = old value, and a later read of 0x20 returns 0x55.
- Lock bound: port 0 holds lock=1 continuously with port 1 valid and MAX_LOCK=15. Expected: port 0 gets 15 grants, port 1 gets the 16th cycle, and port 0 re-locks afterward.
- Illegal write: port 0 asserts word_we=byte_we=1. Expected: mem_word_we=1, mem_byte_we=0, err=1 and still 1 after 10 idle cycles, cleared only by reset=0.
- Asynchronous reset mid-lock: drop reset between clock edges while in LCK1 with a response pending. Expected: outputs reach their reset values immediately. After release, both ports valid gives port 0 the grant.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data memory arbiter with bounded lock
module dmem_arbiter #(
    parameter int WIDTH    = 64,
    parameter int MAX_LOCK = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_addr,
    input  logic [WIDTH-1:0] req0_wdata,
    input  logic             req0_word_we,
    input  logic             req0_byte_we,
    input  logic             req0_lock,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_rdata,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_addr,
    input  logic [WIDTH-1:0] req1_wdata,
    input  logic             req1_word_we,
    input  logic             req1_byte_we,
    input  logic             req1_lock,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_word_we,
    output logic             mem_byte_we,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             owner,
    output logic             err
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

    typedef enum logic [2:0] {IDLE, GNT0, GNT1, LCK0, LCK1} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   lock_cnt, lock_cnt_nxt, lock_base, cnt_inc;
    logic            last_win, last_win_nxt;
    logic            grant, win;
    logic [WIDTH-1:0] sel_addr, sel_wdata;
    logic            sel_word, sel_byte, sel_lock;

    // Reset gates the grant so nothing reaches memory while reset is held.
    always_comb begin
        grant = 1'b0;
        win   = 1'b0;
        if (reset) begin
            if (state == LCK0 && req0_valid) begin
                grant = 1'b1;
                win   = 1'b0;
            end else if (state == LCK1 && req1_valid) begin
                grant = 1'b1;
                win   = 1'b1;
            end else if (req0_valid && req1_valid) begin
                grant = 1'b1;
                win   = ~last_win;
            end else if (req0_valid) begin
                grant = 1'b1;
                win   = 1'b0;
            end else if (req1_valid) begin
                grant = 1'b1;
                win   = 1'b1;
            end
        end
    end

    assign sel_addr  = win ? req1_addr    : req0_addr;
    assign sel_wdata = win ? req1_wdata   : req0_wdata;
    assign sel_word  = win ? req1_word_we : req0_word_we;
    assign sel_byte  = win ? req1_byte_we : req0_byte_we;
    assign sel_lock  = win ? req1_lock    : req0_lock;

    // An illegal word+byte write is demoted to a plain word write.
    assign mem_addr    = grant ? sel_addr  : '0;
    assign mem_wdata   = grant ? sel_wdata : '0;
    assign mem_word_we = grant & (sel_word | sel_byte);
    assign mem_byte_we = grant & sel_byte & ~sel_word;
    assign req0_ready  = grant & ~win;
    assign req1_ready  = grant & win;
    assign owner       = win;

    // The lock count only carries over while the same port keeps its lock.
    always_comb begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
        last_win_nxt = last_win;
        lock_base    = '0;
        cnt_inc      = '0;
        if (grant) begin
            last_win_nxt = win;
            if ((state == LCK0 && !win) || (state == LCK1 && win))
                lock_base = lock_cnt;
            cnt_inc = lock_base + 1'b1;
            if (sel_lock && cnt_inc != MAX_CNT) begin
                state_nxt    = win ? LCK1 : LCK0;
                lock_cnt_nxt = cnt_inc;
            end else begin
                state_nxt = win ? GNT1 : GNT0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            last_win   <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_cnt   <= lock_cnt_nxt;
            last_win   <= last_win_nxt;
            rsp0_valid <= grant & ~win;
            rsp1_valid <= grant & win;
            if (grant && !win)
                rsp0_rdata <= mem_rdata;
            if (grant && win)
                rsp1_rdata <= mem_rdata;
            if (grant && sel_word && sel_byte)
                err <= 1'b1;
        end
    end

endmodule
